// File: rtl/step_run_pkg.sv
// Shared types and constants for the single-step/run controller:
// run-state encoding, mode codes and the active-low seven-segment glyph table.
package step_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STEP   = 3'd1,
    S_SLOW   = 3'd2,
    S_FAST   = 3'd3,
    S_HALTED = 3'd4
  } run_state_e;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

  // Bit 0 is segment a, bit 6 is segment g; a 0 lights the segment.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [6:0] SEG_DASH = 7'b0111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_GLYPH[nib];
  endfunction

  function automatic run_state_e mode_state(input logic [1:0] mode);
    case (mode)
      MODE_STEP: return S_STEP;
      MODE_SLOW: return S_SLOW;
      MODE_FAST: return S_FAST;
      default:   return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/step_run_if.sv
// Board/processor-facing signals of the step/run controller; master drives the
// switches, key, halt and probes, slave is the controller itself.
interface step_run_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 8
);
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int DIGITS = DATA_W / 4;

  logic                     KeyStepN;
  logic [1:0]               ModeSel;
  logic [CH_W-1:0]          ChSel;
  logic                     CpuHalt;
  logic [NUM_CH*DATA_W-1:0] Probe;
  logic                     CpuEn;
  logic [15:0]              StepCount;
  logic [2:0]               RunState;
  logic [DIGITS*7-1:0]      Hex;

  modport master (
    output KeyStepN, ModeSel, ChSel, CpuHalt, Probe,
    input  CpuEn, StepCount, RunState, Hex
  );

  modport slave (
    input  KeyStepN, ModeSel, ChSel, CpuHalt, Probe,
    output CpuEn, StepCount, RunState, Hex
  );
endinterface

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// one-cycle press pulse on an accepted 1->0 change of the active-low key.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  localparam int CNT_W = ($clog2(DEBOUNCE_CYC) > 0) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every value is assigned a default first, so no path leaves a latch.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/step_run_ctrl.sv
// Step/run controller: generates the processor clock enable in halt, step,
// slow-run and full-run modes and drives a registered hex probe display.
module step_run_ctrl
  import step_run_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int NUM_CH       = 8,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int RUN_DIV      = 25000000
) (
  input logic       Clk,
  input logic       Reset,
  step_run_if.slave bus
);
  localparam int DIGITS = DATA_W / 4;
  localparam int CH_W   = $clog2(NUM_CH);
  localparam int DIV_W  = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic                press;
  logic [1:0]          mode_s1_q, mode_s2_q;
  logic [CH_W-1:0]     ch_s1_q, ch_s2_q;
  run_state_e          state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                cpu_en_q, cpu_en_d;
  logic [15:0]         step_cnt_q, step_cnt_d;
  logic [DIGITS*7-1:0] hex_q, hex_d;
  logic                ch_valid;
  logic [DATA_W-1:0]   word;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_key_debounce (
    .clk  (Clk),
    .rst_n(Reset),
    .key_n(bus.KeyStepN),
    .press(press)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mode_s1_q <= MODE_HALT;
      mode_s2_q <= MODE_HALT;
      ch_s1_q   <= '0;
      ch_s2_q   <= '0;
    end else begin
      mode_s1_q <= bus.ModeSel;
      mode_s2_q <= mode_s1_q;
      ch_s1_q   <= bus.ChSel;
      ch_s2_q   <= ch_s1_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Halt wins over any simultaneous mode change; HALTED only leaves via mode 00.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:                 state_d = mode_state(mode_s2_q);
      S_STEP, S_SLOW, S_FAST: state_d = bus.CpuHalt ? S_HALTED : mode_state(mode_s2_q);
      S_HALTED:               if (mode_s2_q == MODE_HALT) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Enables are only issued while the state is not about to change, which
  // discards presses and divider wraps that coincide with halt or a mode switch.
  always_comb begin
    cpu_en_d = 1'b0;
    div_d    = '0;
    case (state_q)
      S_STEP: cpu_en_d = press && (state_d == S_STEP);
      S_SLOW: begin
        if (div_q == DIV_LAST) begin
          cpu_en_d = (state_d == S_SLOW);
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_FAST:  cpu_en_d = (state_d == S_FAST);
      default: cpu_en_d = 1'b0;
    endcase
  end

  always_comb begin
    step_cnt_d = step_cnt_q;
    if (cpu_en_q && (step_cnt_q != 16'hFFFF)) step_cnt_d = step_cnt_q + 16'd1;
  end

  assign ch_valid = ({1'b0, ch_s2_q} < CH_LIMIT);

  always_comb begin
    word  = '0;
    hex_d = '1;
    if (ch_valid) word = bus.Probe[ch_s2_q*DATA_W +: DATA_W];
    for (int i = 0; i < DIGITS; i++) begin
      hex_d[7*i +: 7] = ch_valid ? hex_to_seg(word[4*i +: 4]) : SEG_DASH;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      div_q      <= '0;
      cpu_en_q   <= 1'b0;
      step_cnt_q <= '0;
      hex_q      <= '1;
    end else begin
      div_q      <= div_d;
      cpu_en_q   <= cpu_en_d;
      step_cnt_q <= step_cnt_d;
      hex_q      <= hex_d;
    end
  end

  assign bus.CpuEn     = cpu_en_q;
  assign bus.StepCount = step_cnt_q;
  assign bus.RunState  = state_q;
  assign bus.Hex       = hex_q;

endmodule

// File: tb/tb_step_run_ctrl.sv
// Directed/randomised bench for step_run_ctrl with a timing model derived from
// the mode rules (2-flop sync + one state register) and a letter-based glyph model.
module tb_step_run_ctrl;
  import step_run_pkg::*;

  localparam int DATA_W       = 16;
  localparam int NUM_CH       = 8;
  localparam int DEBOUNCE_CYC = 4;
  localparam int RUN_DIV      = 5;
  localparam int DIGITS       = DATA_W / 4;
  localparam int ENTRY_LAT    = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_steps = 0;
  logic [DATA_W-1:0] words [NUM_CH];

  step_run_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

  step_run_ctrl #(
    .DATA_W      (DATA_W),
    .NUM_CH      (NUM_CH),
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .RUN_DIV     (RUN_DIV)
  ) dut (
    .Clk  (clk),
    .Reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_en(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.CpuEn === 1'b1) highs++;
    end
  endtask

  task automatic load_probe();
    for (int c = 0; c < NUM_CH; c++) bus.Probe[c*DATA_W +: DATA_W] = words[c];
  endtask

  // Glyphs described by which segments are lit, then inverted to active-low.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    string lit;
    logic [6:0] seg;
    case (n)
      4'h0: lit = "abcdef";  4'h1: lit = "bc";
      4'h2: lit = "abdeg";   4'h3: lit = "abcdg";
      4'h4: lit = "bcfg";    4'h5: lit = "acdfg";
      4'h6: lit = "acdefg";  4'h7: lit = "abc";
      4'h8: lit = "abcdefg"; 4'h9: lit = "abcdfg";
      4'hA: lit = "abcefg";  4'hB: lit = "cdefg";
      4'hC: lit = "adef";    4'hD: lit = "bcdeg";
      4'hE: lit = "adefg";   default: lit = "aefg";
    endcase
    seg = '1;
    for (int k = 0; k < lit.len(); k++) begin
      int idx;
      idx = int'(lit[k]) - 97;
      seg[idx] = 1'b0;
    end
    return seg;
  endfunction

  function automatic logic [DIGITS*7-1:0] exp_hex(input logic [DATA_W-1:0] w);
    logic [DIGITS*7-1:0] h;
    for (int i = 0; i < DIGITS; i++) h[7*i +: 7] = glyph(w[4*i +: 4]);
    return h;
  endfunction

  // Slow-run pulse due at sample s (s samples after the mode switch was driven).
  function automatic logic slow_due(input int s);
    return (s > ENTRY_LAT) && (((s - ENTRY_LAT) % RUN_DIV) == 0);
  endfunction

  initial begin
    int   highs, h2, glitch, hold, run_len, fast_len, ch, sat_len;
    logic exp_en;
    longint total;

    rst_n        = 1'b0;
    bus.KeyStepN = 1'b1;
    bus.ModeSel  = MODE_HALT;
    bus.ChSel    = '0;
    bus.CpuHalt  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) words[c] = '0;
    load_probe();
    tick(3);

    // Reset values, then reset asserted asynchronously in full-run.
    check("rst_cpu_en", 64'(bus.CpuEn), 64'(0));
    check("rst_hex", 64'(bus.Hex), {36'd0, {(DIGITS*7){1'b1}}});
    rst_n = 1'b1;
    bus.ModeSel = MODE_FAST;
    tick(ENTRY_LAT + 1 + 10);
    check("fast_pre_reset_en", 64'(bus.CpuEn), 64'(1));
    check("fast_pre_reset_steps", 64'(bus.StepCount), 64'(10));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_cpu_en", 64'(bus.CpuEn), 64'(0));
    check("async_rst_steps", 64'(bus.StepCount), 64'(0));
    check("async_rst_hex", 64'(bus.Hex), {36'd0, {(DIGITS*7){1'b1}}});
    check("async_rst_state", 64'(bus.RunState), 64'(S_IDLE));
    bus.ModeSel = MODE_HALT;
    @(negedge clk);
    rst_n = 1'b1;
    tick(ENTRY_LAT + 1);
    check("idle_after_reset", 64'(bus.RunState), 64'(S_IDLE));
    check("idle_cpu_en", 64'(bus.CpuEn), 64'(0));

    // Step mode: short glitches are ignored, each real press gives one pulse.
    bus.ModeSel = MODE_STEP;
    tick(ENTRY_LAT);
    check("step_state", 64'(bus.RunState), 64'(S_STEP));
    bus.KeyStepN = 1'b0;
    tick(2);
    bus.KeyStepN = 1'b1;
    count_en(20, highs);
    check("glitch2_no_step", 64'(highs), 64'(0));
    for (int p = 0; p < 3; p++) begin
      glitch = $urandom_range(1, DEBOUNCE_CYC - 1);
      hold   = (p == 0) ? 10 : (p == 2) ? 50 : $urandom_range(10, 40);
      bus.KeyStepN = 1'b0;
      count_en(glitch, highs);
      bus.KeyStepN = 1'b1;
      count_en(6, h2);
      highs += h2;
      bus.KeyStepN = 1'b0;
      count_en(hold, h2);
      highs += h2;
      bus.KeyStepN = 1'b1;
      count_en(20, h2);
      highs += h2;
      check("press_one_pulse", 64'(highs), 64'(1));
      exp_steps++;
      check("press_step_count", 64'(bus.StepCount), 64'(exp_steps));
    end

    // Slow-run: cycle-by-cycle against the divider rule.
    run_len = 23 + $urandom_range(0, 6);
    bus.ModeSel = MODE_SLOW;
    for (int s = 1; s <= run_len; s++) begin
      @(negedge clk);
      exp_en = slow_due(s);
      check("slow_steps", 64'(bus.StepCount), 64'(exp_steps));
      check("slow_cpu_en", 64'(bus.CpuEn), 64'(exp_en));
      if (exp_en) exp_steps++;
    end

    // Slow -> full-run: slow rule persists until the new mode is synchronised.
    fast_len = $urandom_range(10, 20);
    bus.ModeSel = MODE_FAST;
    for (int t = 1; t <= ENTRY_LAT + fast_len; t++) begin
      @(negedge clk);
      if (t < ENTRY_LAT) exp_en = slow_due(run_len + t);
      else               exp_en = (t > ENTRY_LAT);
      check("fast_steps", 64'(bus.StepCount), 64'(exp_steps));
      check("fast_cpu_en", 64'(bus.CpuEn), 64'(exp_en));
      if (exp_en) exp_steps++;
    end
    bus.CpuHalt = 1'b1;
    @(negedge clk);
    bus.CpuHalt = 1'b0;
    check("halt_cpu_en_drop", 64'(bus.CpuEn), 64'(0));
    check("halt_state", 64'(bus.RunState), 64'(S_HALTED));
    check("halt_steps", 64'(bus.StepCount), 64'(exp_steps));

    // Halted ignores step mode and presses; only mode 00 exits.
    bus.ModeSel = MODE_STEP;
    bus.KeyStepN = 1'b0;
    count_en(12, highs);
    bus.KeyStepN = 1'b1;
    count_en(20, h2);
    check("halted_no_en", 64'(highs + h2), 64'(0));
    check("halted_sticky", 64'(bus.RunState), 64'(S_HALTED));
    bus.ModeSel = MODE_HALT;
    tick(ENTRY_LAT);
    check("halted_to_idle", 64'(bus.RunState), 64'(S_IDLE));
    check("halted_steps_kept", 64'(bus.StepCount), 64'(exp_steps));

    // Display.
    for (int c = 0; c < NUM_CH; c++) words[c] = DATA_W'($urandom);
    words[3] = 16'hBEEF;
    words[2] = 16'h0000;
    load_probe();
    bus.ChSel = 3'd3;
    tick(ENTRY_LAT);
    check("hex_beef", 64'(bus.Hex), 64'(exp_hex(16'hBEEF)));
    bus.ChSel = 3'd2;
    tick(ENTRY_LAT);
    check("hex_zero", 64'(bus.Hex), 64'(exp_hex(16'h0000)));
    words[2] = DATA_W'($urandom);
    load_probe();
    tick(1);
    check("hex_probe_latency", 64'(bus.Hex), 64'(exp_hex(words[2])));
    for (int r = 0; r < 4; r++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      words[ch] = DATA_W'($urandom);
      load_probe();
      bus.ChSel = 3'(ch);
      tick(ENTRY_LAT);
      check("hex_random", 64'(bus.Hex), 64'(exp_hex(words[ch])));
    end

    // Saturation of StepCount in long full-run.
    sat_len = 65545;
    bus.ModeSel = MODE_FAST;
    tick(sat_len);
    total = longint'(exp_steps) + longint'(sat_len - ENTRY_LAT - 1);
    if (total > 65535) total = 65535;
    check("sat_cpu_en", 64'(bus.CpuEn), 64'(1));
    check("sat_step_count", 64'(bus.StepCount), 64'(total));
    tick(5);
    check("sat_hold", 64'(bus.StepCount), 64'(16'hFFFF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
